fpu_issue_wb: RTL and testbench
===============================

# fpu_issue_wb

Issue and writeback controller for the FP datapath: accepts decoded FP instructions, checks RAW/WAW hazards against outstanding destinations, drives the register-file read addresses and the FPU request handshake, and writes FPU results back into the FP register file. It sits directly upstream and downstream of `fpu_registerfile`. It supplies `rs1/rs2/rs3` and consumes `apu_operands_i_*` via the FPU. It also produces `rd`, `rd_data` and `register_file_enable`.

## Interface
Parameters:
- `DEPTH`, 4: maximum in-flight FPU operations (tag FIFO depth, power of two ≥2).

Ports:
- `clock` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-high.
- `instr_valid` in 1 / `instr_ready` out 1: upstream handshake; transfer when both high.
- `instr_rs1`, `instr_rs2`, `instr_rs3`, `instr_rd` in 5 each: source/destination FP registers.
- `instr_uses_rs3` in 1: rs3 participates in hazard check (fused ops).
- `instr_op` in 6: FPU operation code.
- `rs1`, `rs2`, `rs3` out 5 each: register-file read addresses; combinational copies of `instr_rs*`.
- `apu_req` out 1 / `apu_gnt` in 1: FPU request handshake.
- `apu_op` out 6: combinational copy of `instr_op`.
- `apu_rvalid` in 1, `apu_result` in 32, `apu_fflags` in 5: FPU result; in-order, one per accepted request.
- `rd` out 5, `rd_data` out 32, `register_file_enable` out 1: registered writeback to the register file.
- `fflags_clear` in 1, `fflags_acc` out 5: sticky exception flags.
- `busy` out 1, `protocol_error` out 1 (sticky).

## Operation
- `pending[31:0]` holds one bit per register, set while a write to that register is outstanding.
- `wb_clear` is one-hot at `rd` when `register_file_enable` is high; the effective pending set is `pending & ~wb_clear`. This is a same-cycle bypass, valid because the register file writes on the negedge.
- Hazard condition: effective pending at `instr_rs1`, or at `instr_rs2`, or at `instr_rs3` when `instr_uses_rs3`, or at `instr_rd` (WAW).
- `apu_req` = `instr_valid` & ~hazard & ~full. `instr_ready` = `apu_req` & `apu_gnt`. Issue happens when `instr_ready` is high.
- On issue:
  - `instr_rd` is pushed into the tag FIFO.
  - `pending[instr_rd]` is set unless `instr_rd` is 0; f0 is never written.
  - Set beats clear on the same index in the same cycle.
- On `apu_rvalid` with the FIFO non-empty:
  - Pop the head.
  - Next cycle: `rd` = head, `rd_data` = `apu_result`, and `register_file_enable` = 1 if head ≠ 0.
  - `pending[head]` clears in that writeback cycle.
  - `fflags_acc |= apu_fflags`.
- `apu_rvalid` with the FIFO empty: ignored; sets `protocol_error`.
- `fflags_clear` zeroes `fflags_acc`. If it coincides with new flags, the new flags win (OR applied after clear).
- Full is `count == DEPTH`. Push is blocked when full even if a pop occurs in the same cycle. Push and pop in the same cycle when not full leave `count` unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; `count` is log2(DEPTH)+1 bits.
- `busy` = (`count` ≠ 0) | `register_file_enable`.

## Timing
- Reset values:
  - `register_file_enable`, `rd`, `rd_data`, `fflags_acc`, `protocol_error`: 0.
  - `pending`: 0. FIFO: empty.
  - `busy`, `apu_req`, `instr_ready`: 0 while inputs are idle.
- Reset asserted mid-operation discards in-flight tags and pending bits immediately. Results arriving after reset release set `protocol_error`.
- Issue latency: combinational (`apu_req` is asserted in the same cycle as `instr_valid`).
- Writeback latency: `apu_rvalid` in cycle N gives `register_file_enable` in cycle N+1, held for exactly one cycle. A dependent instruction can issue in cycle N+1.
- Back-to-back `apu_rvalid` produces a consecutive writeback every cycle.

## Structure
- `fpu_pkg` holds:
  - `FLEN` = 32, `REG_AW` = 5, `OP_W` = 6, `FFLAGS_W` = 5.
  - `typedef logic [REG_AW-1:0] freg_t`.
- One sub-module, `fpu_tag_fifo`: a DEPTH × `freg_t` circular buffer exposing push, pop, head, full, empty and count.

## Test plan
- Reset, then issue op with rd=3, rs1=1, rs2=2; `apu_gnt` = 1; `apu_rvalid` 4 cycles later with result 0x40400000 → one-cycle writeback rd=3, data=0x40400000; `pending[3]` clear afterwards.
- RAW: issue rd=5, then an op with rs1=5 → stalled (`apu_req` = 0) until the writeback cycle, when it issues in that same cycle.
- WAW and f0: issue with rd=0 → no `register_file_enable`, but FIFO order is kept; two writes to rd=7 → the second waits for the first writeback.
- Fill DEPTH=4 with rvalid held low → fifth instruction is blocked with `instr_ready` = 0. Then 4 back-to-back rvalids → writebacks rd in order on 4 consecutive cycles; pointers wrap.
- `apu_fflags` 0x01 then 0x10 → `fflags_acc` = 0x11. `fflags_clear` coinciding with 0x04 → `fflags_acc` = 0x04.
- `apu_rvalid` with the FIFO empty → `protocol_error` = 1 and no writeback. Reset mid-flight with 2 tags → `busy` = 0 and `pending` = 0 immediately.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared widths and types for the FP issue/writeback slice.
package fpu_pkg;

  localparam int FLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int OP_W     = 6;
  localparam int FFLAGS_W = 5;

  typedef logic [REG_AW-1:0] freg_t;

endpackage

// File: rtl/fpu_tag_fifo.sv
// Circular buffer of destination tags for in-flight FPU operations.
// Results return in order, so the head is always the destination of the next result.
module fpu_tag_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  freg_t                      push_data,
  input  logic                       pop,
  output freg_t                      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  freg_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push into a full buffer is dropped even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Tag storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_wb.sv
// FP issue and writeback controller: RAW/WAW scoreboard, FPU request handshake,
// in-order tag tracking and registered register-file writeback.
//
// Handshakes: instr_valid/instr_ready and apu_req/apu_gnt transfer in a cycle
// where both sides are high; apu_req never depends on apu_gnt, and instr_ready
// is exactly apu_req & apu_gnt, so an instruction issues in the cycle the FPU
// grants it. apu_rvalid is a one-cycle pulse per result with no back-pressure.
module fpu_issue_wb
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  freg_t               instr_rs1,
  input  freg_t               instr_rs2,
  input  freg_t               instr_rs3,
  input  freg_t               instr_rd,
  input  logic                instr_uses_rs3,
  input  logic [OP_W-1:0]     instr_op,
  output freg_t               rs1,
  output freg_t               rs2,
  output freg_t               rs3,
  output logic                apu_req,
  input  logic                apu_gnt,
  output logic [OP_W-1:0]     apu_op,
  input  logic                apu_rvalid,
  input  logic [FLEN-1:0]     apu_result,
  input  logic [FFLAGS_W-1:0] apu_fflags,
  output freg_t               rd,
  output logic [FLEN-1:0]     rd_data,
  output logic                register_file_enable,
  input  logic                fflags_clear,
  output logic [FFLAGS_W-1:0] fflags_acc,
  output logic                busy,
  output logic                protocol_error
);

  logic [31:0]             pending;
  logic [31:0]             wb_clear;
  logic [31:0]             eff_pending;
  logic [31:0]             set_mask;
  logic                    hazard;
  logic                    issue;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  freg_t                   fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign rs1    = instr_rs1;
  assign rs2    = instr_rs2;
  assign rs3    = instr_rs3;
  assign apu_op = instr_op;

  // The register file writes on the negedge, so the register being written
  // this cycle is already safe to read: drop it from the hazard view.
  assign wb_clear    = register_file_enable ? (32'd1 << rd) : 32'd0;
  assign eff_pending = pending & ~wb_clear;

  assign hazard = eff_pending[instr_rs1] | eff_pending[instr_rs2] |
                  (instr_uses_rs3 & eff_pending[instr_rs3]) |
                  eff_pending[instr_rd];

  assign apu_req     = instr_valid & ~hazard & ~fifo_full;
  assign instr_ready = apu_req & apu_gnt;
  assign issue       = instr_ready;
  assign pop         = apu_rvalid & ~fifo_empty;

  // f0 is hard-wired and never becomes pending.
  assign set_mask = (issue && instr_rd != '0) ? (32'd1 << instr_rd) : 32'd0;

  assign busy = (fifo_count != '0) | register_file_enable;

  fpu_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (issue),
    .push_data (instr_rd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Scoreboard: clear on writeback, set on issue; set wins on the same index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= eff_pending | set_mask;
  end

  // Registered writeback, sticky flags and protocol error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      register_file_enable <= 1'b0;
      rd                   <= '0;
      rd_data              <= '0;
      fflags_acc           <= '0;
      protocol_error       <= 1'b0;
    end else begin
      register_file_enable <= pop && (fifo_head != '0);
      if (pop) begin
        rd      <= fifo_head;
        rd_data <= apu_result;
      end
      // New flags are ORed after the clear so they survive a coincident clear.
      if (pop)               fflags_acc <= (fflags_clear ? '0 : fflags_acc) | apu_fflags;
      else if (fflags_clear) fflags_acc <= '0;
      if (apu_rvalid && fifo_empty) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_wb.sv
// Directed bench for fpu_issue_wb: linear sequence of steps with hand-computed expectations.
module tb_fpu_issue_wb;
  import fpu_pkg::*;

  logic                clock;
  logic                reset;
  logic                instr_valid;
  logic                instr_ready;
  freg_t               instr_rs1, instr_rs2, instr_rs3, instr_rd;
  logic                instr_uses_rs3;
  logic [OP_W-1:0]     instr_op;
  freg_t               rs1, rs2, rs3;
  logic                apu_req;
  logic                apu_gnt;
  logic [OP_W-1:0]     apu_op;
  logic                apu_rvalid;
  logic [FLEN-1:0]     apu_result;
  logic [FFLAGS_W-1:0] apu_fflags;
  freg_t               rd;
  logic [FLEN-1:0]     rd_data;
  logic                register_file_enable;
  logic                fflags_clear;
  logic [FFLAGS_W-1:0] fflags_acc;
  logic                busy;
  logic                protocol_error;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_issue_wb #(.DEPTH(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instr_rs1            (instr_rs1),
    .instr_rs2            (instr_rs2),
    .instr_rs3            (instr_rs3),
    .instr_rd             (instr_rd),
    .instr_uses_rs3       (instr_uses_rs3),
    .instr_op             (instr_op),
    .rs1                  (rs1),
    .rs2                  (rs2),
    .rs3                  (rs3),
    .apu_req              (apu_req),
    .apu_gnt              (apu_gnt),
    .apu_op               (apu_op),
    .apu_rvalid           (apu_rvalid),
    .apu_result           (apu_result),
    .apu_fflags           (apu_fflags),
    .rd                   (rd),
    .rd_data              (rd_data),
    .register_file_enable (register_file_enable),
    .fflags_clear         (fflags_clear),
    .fflags_acc           (fflags_acc),
    .busy                 (busy),
    .protocol_error       (protocol_error)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_instr(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    instr_valid = 1'b1;
    instr_rd    = d;
    instr_rs1   = s1;
    instr_rs2   = s2;
    instr_rs3   = '0;
    instr_uses_rs3 = 1'b0;
    instr_op    = 6'h05;
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 0; instr_rs1 = 0; instr_rs2 = 0; instr_rs3 = 0; instr_rd = 0;
    instr_uses_rs3 = 0; instr_op = 0; apu_gnt = 0; apu_rvalid = 0;
    apu_result = 0; apu_fflags = 0; fflags_clear = 0;

    // Reset state
    tick(); tick();
    chk("rst_we",    register_file_enable, 0);
    chk("rst_rd",    rd, 0);
    chk("rst_data",  rd_data, 0);
    chk("rst_flags", fflags_acc, 0);
    chk("rst_perr",  protocol_error, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_req",   apu_req, 0);
    chk("rst_rdy",   instr_ready, 0);
    reset = 1'b0;
    tick();

    // Basic issue and writeback
    drive_instr(5'd3, 5'd1, 5'd2);
    apu_gnt = 1'b1;
    #1;
    chk("t1_req",  apu_req, 1);
    chk("t1_rdy",  instr_ready, 1);
    chk("t1_rs1",  rs1, 1);
    chk("t1_rs2",  rs2, 2);
    chk("t1_op",   apu_op, 6'h05);
    tick();
    instr_valid = 0;
    chk("t1_busy", busy, 1);
    chk("t1_pend", dut.pending, 32'h0000_0008);
    tick(); tick(); tick();
    apu_rvalid = 1; apu_result = 32'h4040_0000;
    tick();
    apu_rvalid = 0;
    chk("t1_we",   register_file_enable, 1);
    chk("t1_rd",   rd, 3);
    chk("t1_data", rd_data, 32'h4040_0000);
    tick();
    chk("t1_we_off", register_file_enable, 0);
    chk("t1_pend_clr", dut.pending, 0);
    chk("t1_idle", busy, 0);

    // RAW hazard, plus rs3 participation
    drive_instr(5'd5, 5'd1, 5'd2);
    tick();
    instr_rd = 5'd6; instr_rs3 = 5'd5; instr_uses_rs3 = 0; apu_gnt = 0;
    #1;
    chk("rs3_ignored", apu_req, 1);
    instr_uses_rs3 = 1;
    #1;
    chk("rs3_hazard", apu_req, 0);
    instr_uses_rs3 = 0; instr_rs3 = 0; instr_rs1 = 5'd5; apu_gnt = 1;
    #1;
    chk("raw_stall", apu_req, 0);
    chk("raw_stall_rdy", instr_ready, 0);
    tick();
    chk("raw_stall2", apu_req, 0);
    apu_rvalid = 1; apu_result = 32'h3f80_0000;
    #1;
    chk("raw_stall3", apu_req, 0);
    tick();
    apu_rvalid = 0;
    #1;
    chk("raw_we",     register_file_enable, 1);
    chk("raw_rd",     rd, 5);
    chk("raw_bypass", apu_req, 1);
    chk("raw_bypass_rdy", instr_ready, 1);
    tick();
    instr_valid = 0;
    chk("raw_pend", dut.pending, 32'h0000_0040);
    apu_rvalid = 1; apu_result = 32'h0000_0002;
    tick();
    apu_rvalid = 0;
    chk("raw_wb2_rd", rd, 6);
    chk("raw_wb2_we", register_file_enable, 1);
    tick();

    // f0 destination and WAW
    drive_instr(5'd0, 5'd1, 5'd2);
    tick();
    instr_rd = 5'd7;
    tick();
    #1;
    chk("waw_stall", apu_req, 0);
    apu_rvalid = 1; apu_result = 32'hAAAA_0000;
    tick();
    chk("f0_no_we", register_file_enable, 0);
    chk("f0_rd",    rd, 0);
    #1;
    chk("waw_stall2", apu_req, 0);
    apu_result = 32'hBBBB_0000;
    tick();
    apu_rvalid = 0;
    chk("waw_we",   register_file_enable, 1);
    chk("waw_rd",   rd, 7);
    chk("waw_data", rd_data, 32'hBBBB_0000);
    #1;
    chk("waw_bypass", apu_req, 1);
    tick();
    instr_valid = 0;
    apu_rvalid = 1; apu_result = 32'hCCCC_0000;
    tick();
    apu_rvalid = 0;
    chk("waw2_rd",   rd, 7);
    chk("waw2_data", rd_data, 32'hCCCC_0000);
    tick();

    // Fill the tag FIFO, then drain back-to-back with flag accumulation
    for (int i = 0; i < 4; i++) begin
      drive_instr(5'(8 + i), 5'd1, 5'd2);
      tick();
    end
    instr_rd = 5'd12;
    #1;
    chk("full_req",  apu_req, 0);
    chk("full_rdy",  instr_ready, 0);
    chk("full_busy", busy, 1);
    apu_rvalid = 1; apu_result = 32'h0000_0010; apu_fflags = 5'h01;
    #1;
    chk("full_pop_block", instr_ready, 0);
    tick();
    instr_valid = 0;
    chk("drain0_rd",   rd, 8);
    chk("drain0_data", rd_data, 32'h0000_0010);
    chk("drain0_flags", fflags_acc, 5'h01);
    for (int i = 1; i < 4; i++) begin
      apu_result = 32'(16 + i);
      apu_fflags = (i == 1) ? 5'h10 : 5'h00;
      tick();
      chk("drain_we",   register_file_enable, 1);
      chk("drain_rd",   rd, 32'(8 + i));
      chk("drain_data", rd_data, 32'(16 + i));
    end
    apu_rvalid = 0; apu_fflags = 0;
    chk("flags_acc", fflags_acc, 5'h11);
    tick();
    chk("drain_done_we", register_file_enable, 0);
    chk("drain_done_busy", busy, 0);

    // Flag clear coinciding with new flags
    drive_instr(5'd13, 5'd1, 5'd2);
    tick();
    instr_valid = 0;
    apu_rvalid = 1; apu_result = 32'h1; apu_fflags = 5'h04; fflags_clear = 1;
    tick();
    apu_rvalid = 0; apu_fflags = 0; fflags_clear = 0;
    chk("clr_new_wins", fflags_acc, 5'h04);
    chk("clr_rd", rd, 13);
    fflags_clear = 1;
    tick();
    fflags_clear = 0;
    chk("clr_only", fflags_acc, 0);

    // Result with empty FIFO
    apu_rvalid = 1; apu_result = 32'hDEAD_BEEF;
    tick();
    apu_rvalid = 0;
    chk("perr_set",   protocol_error, 1);
    chk("perr_no_we", register_file_enable, 0);
    chk("perr_busy",  busy, 0);
    tick();
    chk("perr_sticky", protocol_error, 1);

    // Reset mid-flight
    drive_instr(5'd14, 5'd1, 5'd2);
    tick();
    instr_rd = 5'd15;
    tick();
    instr_valid = 0;
    chk("mid_busy", busy, 1);
    chk("mid_pend", dut.pending, 32'h0000_C000);
    reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pend", dut.pending, 0);
    chk("mid_rst_perr", protocol_error, 0);
    tick();
    reset = 0;
    tick();
    apu_rvalid = 1; apu_result = 32'h1234_5678;
    tick();
    apu_rvalid = 0;
    chk("post_rst_perr", protocol_error, 1);
    chk("post_rst_we",   register_file_enable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
